// File: rtl/systolic_feeder_if.sv
// rtl/systolic_feeder_if.sv - operand-write, control and array-edge bundle for systolic_feeder
//
// master: drives operand writes and start, observes status and array edge signals.
// slave : the feeder itself.
//   wr_en/wr_sel/wr_row/wr_col/wr_data : one operand element write (sel 0 = A, 1 = B)
//   wr_ready                           : writes accepted (feeder idle)
//   start/busy/done                    : sequence request, in-progress flag, completion pulse
//   load_en/mult_en/acc_en             : array control enables
//   a_in[SIZE]/b_in[SIZE]              : left-edge (per row) and top-edge (per column) operands
interface systolic_feeder_if #(
    parameter int SIZE     = 3,
    parameter int IN_WIDTH = 8
);
    localparam int IDXW = $clog2(SIZE);

    logic                wr_en;
    logic                wr_sel;
    logic [IDXW-1:0]     wr_row;
    logic [IDXW-1:0]     wr_col;
    logic [IN_WIDTH-1:0] wr_data;
    logic                wr_ready;
    logic                start;
    logic                busy;
    logic                done;
    logic                load_en;
    logic                mult_en;
    logic                acc_en;
    logic [IN_WIDTH-1:0] a_in [SIZE];
    logic [IN_WIDTH-1:0] b_in [SIZE];

    modport master (
        output wr_en, wr_sel, wr_row, wr_col, wr_data, start,
        input  wr_ready, busy, done, load_en, mult_en, acc_en, a_in, b_in
    );

    modport slave (
        input  wr_en, wr_sel, wr_row, wr_col, wr_data, start,
        output wr_ready, busy, done, load_en, mult_en, acc_en, a_in, b_in
    );
endinterface

// File: rtl/systolic_feeder.sv
// rtl/systolic_feeder.sv - operand buffer and skewed wavefront sequencer for an output-stationary systolic array
//
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : systolic_feeder_if.slave (operand writes, start/busy/done, array enables, a_in/b_in edges)
// Optional build macro: SYSTOLIC_FEEDER_TRANSPOSE_B_EN - B writes land at B[col][row].
// Sequence: IDLE -> CLEAR (load_en) -> STREAM (3*SIZE-2 steps) -> DRAIN (DRAIN_CYCLES) -> DONE -> IDLE.
module systolic_feeder #(
    parameter int SIZE         = 3,
    parameter int IN_WIDTH     = 8,
    parameter int DRAIN_CYCLES = 1
) (
    input logic               clk,
    input logic               reset,
    systolic_feeder_if.slave  bus
);
    localparam int IDXW  = $clog2(SIZE);
    localparam int STEPS = 3 * SIZE - 2;
    localparam int STEPW = $clog2(STEPS);
    localparam int DRW   = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              state;
    logic [STEPW-1:0]    step;
    logic [DRW-1:0]      drain_cnt;
    logic                busy_q;
    logic                wr_ready_q;
    logic                done_q;
    logic                load_q;
    logic                mult_q;
    logic                acc_q;
    logic [IN_WIDTH-1:0] a_q   [SIZE];
    logic [IN_WIDTH-1:0] b_q   [SIZE];
    logic [IN_WIDTH-1:0] nxt_a [SIZE];
    logic [IN_WIDTH-1:0] nxt_b [SIZE];
    logic [IN_WIDTH-1:0] mem_a [SIZE][SIZE];
    logic [IN_WIDTH-1:0] mem_b [SIZE][SIZE];
    logic                wr_in_range;
    int                  fetch_t;

    assign wr_in_range = (int'(bus.wr_row) < SIZE) && (int'(bus.wr_col) < SIZE);

    // Edge values are registered, so they are fetched one step ahead: in CLEAR
    // the wavefront for t=0 is prepared, in STREAM step t the one for t+1.
    always_comb begin
        fetch_t = (state == S_STREAM) ? int'(step) + 1 : 0;
        for (int i = 0; i < SIZE; i++) begin
            nxt_a[i] = '0;
            nxt_b[i] = '0;
            if ((fetch_t - i >= 0) && (fetch_t - i < SIZE)) begin
                nxt_a[i] = mem_a[IDXW'(i)][IDXW'(fetch_t - i)];
                nxt_b[i] = mem_b[IDXW'(fetch_t - i)][IDXW'(i)];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            step       <= '0;
            drain_cnt  <= '0;
            busy_q     <= 1'b0;
            wr_ready_q <= 1'b1;
            done_q     <= 1'b0;
            load_q     <= 1'b0;
            mult_q     <= 1'b0;
            acc_q      <= 1'b0;
            for (int i = 0; i < SIZE; i++) begin
                a_q[i] <= '0;
                b_q[i] <= '0;
                for (int j = 0; j < SIZE; j++) begin
                    mem_a[IDXW'(i)][IDXW'(j)] <= '0;
                    mem_b[IDXW'(i)][IDXW'(j)] <= '0;
                end
            end
        end else begin
            done_q <= 1'b0;

            // A write landing in the same cycle as start is stored before CLEAR
            // fetches step 0, so the new sequence sees it.
            if (state == S_IDLE && bus.wr_en && wr_in_range) begin
                if (!bus.wr_sel) begin
                    mem_a[bus.wr_row][bus.wr_col] <= bus.wr_data;
                end else begin
`ifdef SYSTOLIC_FEEDER_TRANSPOSE_B_EN
                    mem_b[bus.wr_col][bus.wr_row] <= bus.wr_data;
`else
                    mem_b[bus.wr_row][bus.wr_col] <= bus.wr_data;
`endif
                end
            end

            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state      <= S_CLEAR;
                        busy_q     <= 1'b1;
                        wr_ready_q <= 1'b0;
                        load_q     <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    state  <= S_STREAM;
                    step   <= '0;
                    load_q <= 1'b0;
                    mult_q <= 1'b1;
                    acc_q  <= 1'b1;
                    a_q    <= nxt_a;
                    b_q    <= nxt_b;
                end
                S_STREAM: begin
                    if (step == STEPW'(STEPS - 1)) begin
                        mult_q <= 1'b0;
                        for (int i = 0; i < SIZE; i++) begin
                            a_q[i] <= '0;
                            b_q[i] <= '0;
                        end
                        if (DRAIN_CYCLES > 0) begin
                            state     <= S_DRAIN;
                            drain_cnt <= '0;
                        end else begin
                            state  <= S_DONE;
                            acc_q  <= 1'b0;
                            done_q <= 1'b1;
                        end
                    end else begin
                        step <= step + 1'b1;
                        a_q  <= nxt_a;
                        b_q  <= nxt_b;
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt == DRW'(DRAIN_CYCLES - 1)) begin
                        state  <= S_DONE;
                        acc_q  <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    // start is not looked at here, so a held start always
                    // leaves at least one IDLE cycle between sequences.
                    state      <= S_IDLE;
                    busy_q     <= 1'b0;
                    wr_ready_q <= 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.wr_ready = wr_ready_q;
    assign bus.done     = done_q;
    assign bus.load_en  = load_q;
    assign bus.mult_en  = mult_q;
    assign bus.acc_en   = acc_q;
    assign bus.a_in     = a_q;
    assign bus.b_in     = b_q;
endmodule

// File: tb/tb_systolic_feeder.sv
// tb/tb_systolic_feeder.sv - self-checking bench for systolic_feeder
module tb_systolic_feeder;
    localparam int SIZE     = 3;
    localparam int IN_WIDTH = 8;
    localparam int DRAIN    = 1;
    localparam int STEPS    = 3 * SIZE - 2;
    localparam int LAT      = 1 + STEPS + DRAIN + 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    systolic_feeder_if #(.SIZE(SIZE), .IN_WIDTH(IN_WIDTH)) bus ();
    systolic_feeder #(.SIZE(SIZE), .IN_WIDTH(IN_WIDTH), .DRAIN_CYCLES(DRAIN)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_pass = 0;
    int n_total = 0;

    int model_a [SIZE][SIZE];
    int model_b [SIZE][SIZE];
    int exp_a [STEPS][SIZE];
    int exp_b [STEPS][SIZE];
    int cap_a [16][SIZE];
    int cap_b [16][SIZE];
    int n_mult, n_load, n_done, load_c, first_mult_c, done_c, stray, idle_after;

    // Each row's stream is: i leading zeros, the row of A, then zero padding.
    // Each column's stream: j leading zeros, the column of B, then zero padding.
    task automatic build_expected();
        for (int i = 0; i < SIZE; i++) begin
            int qa[$];
            int qb[$];
            repeat (i) begin qa.push_back(0); qb.push_back(0); end
            for (int k = 0; k < SIZE; k++) begin
                qa.push_back(model_a[i][k]);
                qb.push_back(model_b[k][i]);
            end
            while (qa.size() < STEPS) begin qa.push_back(0); qb.push_back(0); end
            for (int t = 0; t < STEPS; t++) begin
                exp_a[t][i] = qa[t];
                exp_b[t][i] = qb[t];
            end
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < SIZE; i++)
            for (int j = 0; j < SIZE; j++) begin
                model_a[i][j] = 0;
                model_b[i][j] = 0;
            end
    endtask

    task automatic write_elem(input bit sel, input int r, input int c, input int d);
        @(negedge clk);
        bus.wr_en = 1'b1; bus.wr_sel = sel;
        bus.wr_row = 2'(r); bus.wr_col = 2'(c); bus.wr_data = 8'(d);
        @(negedge clk);
        bus.wr_en = 1'b0;
        if (!sel) model_a[r][c] = d;
`ifdef SYSTOLIC_FEEDER_TRANSPOSE_B_EN
        else model_b[c][r] = d;
`else
        else model_b[r][c] = d;
`endif
    endtask

    // Caller sets start (and optionally a write) at a negedge, then calls this.
    // Cycle c = 1 is the first cycle after the start edge.
    task automatic capture_seq();
        n_mult = 0; n_load = 0; n_done = 0; load_c = 0;
        first_mult_c = 0; done_c = 0; stray = 0; idle_after = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (c == 1) begin bus.start = 1'b0; bus.wr_en = 1'b0; end
            if (bus.load_en) begin n_load++; load_c = c; end
            if (bus.mult_en) begin
                if (n_mult < 16)
                    for (int i = 0; i < SIZE; i++) begin
                        cap_a[n_mult][i] = int'(bus.a_in[i]);
                        cap_b[n_mult][i] = int'(bus.b_in[i]);
                    end
                if (n_mult == 0) first_mult_c = c;
                n_mult++;
                if (!bus.acc_en || bus.load_en) stray++;
            end else begin
                for (int i = 0; i < SIZE; i++)
                    if (bus.a_in[i] !== '0 || bus.b_in[i] !== '0) stray++;
            end
            if (bus.done) begin n_done++; done_c = c; end
            if (done_c != 0 && c == done_c + 1) begin
                idle_after = (!bus.busy && bus.wr_ready) ? 1 : 0;
                break;
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        bus.wr_en = 1'b0; bus.wr_sel = 1'b0; bus.wr_row = '0; bus.wr_col = '0;
        bus.wr_data = '0; bus.start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        clear_model();
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_total++;
        if ({bus.wr_ready, bus.busy, bus.done, bus.load_en, bus.mult_en, bus.acc_en} !== 6'b100000) begin
            $display("FAIL reset_ctrl got %b need 100000",
                {bus.wr_ready, bus.busy, bus.done, bus.load_en, bus.mult_en, bus.acc_en});
        end else n_pass++;
        for (int i = 0; i < SIZE; i++) begin
            n_total++;
            if (bus.a_in[i] !== '0 || bus.b_in[i] !== '0)
                $display("FAIL reset_edge[%0d] got a=%0d b=%0d need 0", i, bus.a_in[i], bus.b_in[i]);
            else n_pass++;
        end
    endtask

    task automatic load_scenario2();
        for (int i = 0; i < SIZE; i++)
            for (int j = 0; j < SIZE; j++) begin
                write_elem(1'b0, i, j, i * SIZE + j + 1);
                write_elem(1'b1, i, j, (i == j) ? 1 : 0);
            end
    endtask

    task automatic test_identity();
        int ea [5][SIZE];
        int eb [5][SIZE];
        int ts [5];
        ts = '{0, 2, 4, 5, 6};
        ea = '{'{1,0,0}, '{3,5,7}, '{0,0,9}, '{0,0,0}, '{0,0,0}};
        eb = '{'{1,0,0}, '{0,1,0}, '{0,0,1}, '{0,0,0}, '{0,0,0}};
        load_scenario2();
        @(negedge clk); bus.start = 1'b1;
        capture_seq();
        n_total++;
        if (n_load !== 1 || load_c !== 1)
            $display("FAIL id_load got n=%0d c=%0d need 1/1", n_load, load_c);
        else n_pass++;
        n_total++;
        if (n_mult !== STEPS || first_mult_c !== 2)
            $display("FAIL id_mult got n=%0d first=%0d need %0d/2", n_mult, first_mult_c, STEPS);
        else n_pass++;
        for (int k = 0; k < 5; k++)
            for (int i = 0; i < SIZE; i++) begin
                n_total++;
                if (cap_a[ts[k]][i] !== ea[k][i] || cap_b[ts[k]][i] !== eb[k][i])
                    $display("FAIL id_edge t=%0d i=%0d got a=%0d b=%0d need a=%0d b=%0d",
                        ts[k], i, cap_a[ts[k]][i], cap_b[ts[k]][i], ea[k][i], eb[k][i]);
                else n_pass++;
            end
        n_total++;
        if (done_c !== LAT || n_done !== 1 || stray !== 0 || idle_after !== 1)
            $display("FAIL id_done got c=%0d n=%0d stray=%0d idle=%0d need %0d/1/0/1",
                done_c, n_done, stray, idle_after, LAT);
        else n_pass++;
    endtask

    task automatic test_busy_writes();
        @(negedge clk); bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        bus.wr_en = 1'b1; bus.wr_sel = 1'b0; bus.wr_row = 2'd0; bus.wr_col = 2'd0; bus.wr_data = 8'd99;
        @(negedge clk);
        bus.wr_sel = 1'b1; bus.wr_data = 8'd42;
        @(negedge clk); bus.wr_en = 1'b0;
        for (int c = 0; c < 20 && bus.busy; c++) @(negedge clk);
        // out-of-range writes while idle
        bus.wr_en = 1'b1; bus.wr_sel = 1'b0; bus.wr_row = 2'd3; bus.wr_col = 2'd0; bus.wr_data = 8'd77;
        @(negedge clk);
        bus.wr_sel = 1'b1; bus.wr_row = 2'd1; bus.wr_col = 2'd3; bus.wr_data = 8'd66;
        @(negedge clk);
        bus.wr_en = 1'b0; bus.start = 1'b1;
        build_expected();
        capture_seq();
        for (int t = 0; t < STEPS; t++)
            for (int i = 0; i < SIZE; i++) begin
                n_total++;
                if (cap_a[t][i] !== exp_a[t][i] || cap_b[t][i] !== exp_b[t][i])
                    $display("FAIL busy_wr t=%0d i=%0d got a=%0d b=%0d need a=%0d b=%0d",
                        t, i, cap_a[t][i], cap_b[t][i], exp_a[t][i], exp_b[t][i]);
                else n_pass++;
            end
    endtask

    task automatic test_same_cycle();
        @(negedge clk);
        bus.start = 1'b1;
        bus.wr_en = 1'b1; bus.wr_sel = 1'b0; bus.wr_row = 2'd2; bus.wr_col = 2'd2; bus.wr_data = 8'd5;
        model_a[2][2] = 5;
        capture_seq();
        n_total++;
        if (cap_a[4][2] !== 5)
            $display("FAIL same_cycle got a_in[2]=%0d need 5", cap_a[4][2]);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < SIZE; i++)
                for (int j = 0; j < SIZE; j++) begin
                    write_elem(1'b0, i, j, int'($urandom_range(255)));
                    write_elem(1'b1, i, j, int'($urandom_range(255)));
                end
            build_expected();
            @(negedge clk); bus.start = 1'b1;
            capture_seq();
            for (int t = 0; t < STEPS; t++)
                for (int i = 0; i < SIZE; i++) begin
                    n_total++;
                    if (cap_a[t][i] !== exp_a[t][i] || cap_b[t][i] !== exp_b[t][i])
                        $display("FAIL rand%0d t=%0d i=%0d got a=%0d b=%0d need a=%0d b=%0d",
                            r, t, i, cap_a[t][i], cap_b[t][i], exp_a[t][i], exp_b[t][i]);
                    else n_pass++;
                end
            n_total++;
            if (done_c !== LAT || n_mult !== STEPS)
                $display("FAIL rand%0d_lat got done=%0d mult=%0d need %0d/%0d", r, done_c, n_mult, LAT, STEPS);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        int dones;
        @(negedge clk); bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        n_total++;
        if ({bus.wr_ready, bus.busy, bus.done, bus.load_en, bus.mult_en, bus.acc_en} !== 6'b100000
            || bus.a_in[2] !== '0 || bus.b_in[1] !== '0)
            $display("FAIL mid_reset got ctrl=%b a2=%0d b1=%0d need 100000/0/0",
                {bus.wr_ready, bus.busy, bus.done, bus.load_en, bus.mult_en, bus.acc_en}, bus.a_in[2], bus.b_in[1]);
        else n_pass++;
        @(negedge clk); reset = 1'b1;
        clear_model();
        dones = 0;
        repeat (15) begin @(negedge clk); if (bus.done) dones++; end
        n_total++;
        if (dones !== 0) $display("FAIL mid_reset_done got %0d need 0", dones);
        else n_pass++;
        build_expected();
        @(negedge clk); bus.start = 1'b1;
        capture_seq();
        for (int t = 0; t < STEPS; t++)
            for (int i = 0; i < SIZE; i++) begin
                n_total++;
                if (cap_a[t][i] !== exp_a[t][i] || cap_b[t][i] !== exp_b[t][i])
                    $display("FAIL mid_reset_zero t=%0d i=%0d got a=%0d b=%0d need 0",
                        t, i, cap_a[t][i], cap_b[t][i]);
                else n_pass++;
            end
    endtask

    task automatic test_transpose();
        do_reset();
        write_elem(1'b1, 0, 1, 7);
        @(negedge clk); bus.start = 1'b1;
        capture_seq();
        n_total++;
`ifdef SYSTOLIC_FEEDER_TRANSPOSE_B_EN
        if (cap_b[1][0] !== 7 || cap_b[1][1] !== 0)
            $display("FAIL transpose got b0=%0d b1=%0d need 7/0", cap_b[1][0], cap_b[1][1]);
`else
        if (cap_b[1][1] !== 7 || cap_b[1][0] !== 0)
            $display("FAIL no_transpose got b0=%0d b1=%0d need 0/7", cap_b[1][0], cap_b[1][1]);
`endif
        else n_pass++;
    endtask

    task automatic test_start_held();
        int dones, loads, gap_bad;
        bit prev_done;
        dones = 0; loads = 0; gap_bad = 0; prev_done = 0;
        @(negedge clk); bus.start = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (c == 39) bus.start = 1'b0;
            if (prev_done && bus.busy) gap_bad++;
            prev_done = bus.done;
            if (bus.done) dones++;
            if (bus.load_en) loads++;
            if (c > 39 && !bus.busy && !prev_done) break;
        end
        n_total++;
        if (gap_bad !== 0) $display("FAIL held_gap got %0d busy-after-done need 0", gap_bad);
        else n_pass++;
        n_total++;
        if (dones !== loads || dones !== 4)
            $display("FAIL held_count got done=%0d load=%0d need 4/4", dones, loads);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_identity();
        test_busy_writes();
        test_same_cycle();
        test_random();
        test_reset_mid();
        test_start_held();
        test_transpose();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
